// File: rtl/instr_encoder.sv
// Assembles MIPS machine words from instruction requests and buffers them in a FIFO,
// emitting each word with its sequential byte address for the instruction-memory loader.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_instr,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [15:0]              in_imm,
    input  logic [25:0]              in_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_word,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic [3:0]               err_instr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [31:0]     addr_q;
    logic            err_q;
    logic [3:0]      err_instr_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        full, empty, in_fire, out_fire, push, pop;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_instr)
            4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            4'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
            4'd2: enc_word = {6'b001101, in_rs, in_rt, in_imm};
            4'd3: enc_word = {6'b100011, in_rs, in_rt, in_imm};
            4'd4: enc_word = {6'b101011, in_rs, in_rt, in_imm};
            4'd5: enc_word = {6'b000100, in_rs, in_rt, in_imm};
            4'd6: enc_word = {6'b001111, 5'b00000, in_rt, in_imm};
            4'd7: enc_word = {6'b000011, in_target};
            4'd8: enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
            4'd9: enc_word = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, 6'b000000};
            default: enc_legal = 1'b0;
        endcase
    end

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    // Holding reset keeps the loader from handing over requests that would be lost.
    assign in_ready = reset & ~full;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_ready & ~empty;
    assign push     = in_fire & enc_legal & ~flush;
    assign pop      = out_fire & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
            err_instr_q <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
            err_instr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                addr_q   <= addr_q + 32'd4;
            end
            if (push && !pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
            if (in_fire && !enc_legal) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_instr_q <= in_instr;
                end
            end
        end
    end

    assign out_valid = ~empty;
    assign out_word  = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_instr = err_instr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed checking of instr_encoder against a queue-based reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready, err;
    logic [3:0]  in_instr, err_instr;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic [31:0] out_word, out_addr;
    logic [2:0]  count;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
    logic [3:0]  w_err_instr;
    logic [31:0] w_out_word, w_out_addr;
    logic [2:0]  w_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mq[$];
    logic [31:0] m_addr;
    logic        m_err;
    logic [3:0]  m_err_instr;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .count(count), .err(err), .err_instr(err_instr)
    );

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WBASE)) u_wrap (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(4'd7),
        .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0), .in_shamt(5'd0),
        .in_imm(16'd0), .in_target(26'd5),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_word(w_out_word),
        .out_addr(w_out_addr), .count(w_count), .err(w_err), .err_instr(w_err_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference encoding built arithmetically from opcode, register slots and funct.
    function automatic logic [31:0] enc(input int code, input int rs, input int rt,
                                        input int rd, input int sh, input int imm,
                                        input int tgt);
        int unsigned w;
        case (code)
            0: w = (rs << 21) + (rt << 16) + (rd << 11) + 33;
            1: w = (rs << 21) + (rt << 16) + (rd << 11) + 35;
            2: w = (13 << 26) + (rs << 21) + (rt << 16) + imm;
            3: w = (35 << 26) + (rs << 21) + (rt << 16) + imm;
            4: w = (43 << 26) + (rs << 21) + (rt << 16) + imm;
            5: w = (4 << 26) + (rs << 21) + (rt << 16) + imm;
            6: w = (15 << 26) + (rt << 16) + imm;
            7: w = (3 << 26) + tgt;
            8: w = (rs << 21) + 8;
            default: w = (rt << 16) + (rd << 11) + (sh << 6);
        endcase
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr      = BASE;
        m_err       = 1'b0;
        m_err_instr = 4'd0;
    endtask

    task automatic compare_all();
        check("in_ready", in_ready, mq.size() < DEPTH);
        check("out_valid", out_valid, mq.size() > 0);
        check("out_word", out_word, (mq.size() > 0) ? mq[0] : 32'h0);
        check("out_addr", out_addr, m_addr);
        check("count", count, mq.size());
        check("err", err, m_err);
        check("err_instr", err_instr, m_err_instr);
    endtask

    // Drives one cycle from a negedge, advances the model and compares at the next negedge.
    task automatic cycle(input logic v, input int code, input int rs, input int rt, input int rd,
                         input int sh, input int imm, input int tgt, input logic ordy,
                         input logic fl);
        bit in_fire, out_fire;
        in_valid = v; in_instr = 4'(code); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
        out_ready = ordy; flush = fl;
        in_fire  = v && (mq.size() < DEPTH);
        out_fire = ordy && (mq.size() > 0);
        if (fl) begin
            model_reset();
        end else begin
            if (out_fire) begin
                void'(mq.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (in_fire) begin
                if (code < 10) begin
                    mq.push_back(enc(code, rs, rt, rd, sh, imm, tgt));
                end else begin
                    if (!m_err) m_err_instr = 4'(code);
                    m_err = 1'b1;
                end
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, ordy, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_words [4];
        logic [31:0] waddr [3];
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("ready_in_reset", in_ready, 1'b0);
        check("word_in_reset", out_word, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        compare_all();

        // Single addu then pop.
        cycle(1'b1, 0, 1, 2, 3, 0, 0, 0, 1'b0, 1'b0);
        check("addu_word", out_word, 32'h0022_1821);
        check("addu_addr", out_addr, 32'h0000_3000);
        idle(1'b1);
        check("addr_after_pop", out_addr, 32'h0000_3004);

        // Fill with four words while the consumer stalls, then drain in order.
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 2, 0, 8, 0, 0, 'h1234, 0, 1'b0, 1'b0);
        cycle(1'b1, 6, 0, 9, 0, 0, 'hABCD, 0, 1'b0, 1'b0);
        cycle(1'b1, 9, 0, 8, 10, 2, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 7, 0, 0, 0, 0, 0, 'hC00, 1'b0, 1'b0);
        check("full_count", count, 3'd4);
        check("full_ready", in_ready, 1'b0);
        exp_words[0] = 32'h3408_1234; exp_words[1] = 32'h3C09_ABCD;
        exp_words[2] = 32'h0008_5080; exp_words[3] = 32'h0C00_0C00;
        for (int i = 0; i < 4; i++) begin
            check("drain_word", out_word, exp_words[i]);
            check("drain_addr", out_addr, BASE + 32'(4 * i));
            idle(1'b1);
        end

        // Full with simultaneous request and pop: no bypass, request taken next cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 0, i, i, i, 0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1, 7, 7, 7, 0, 0, 0, 1'b1, 1'b0);
        check("no_bypass_count", count, 3'd3);
        cycle(1'b1, 1, 7, 7, 7, 0, 0, 0, 1'b0, 1'b0);
        check("held_accepted", count, 3'd4);

        // Illegal codes: sticky error, first code latched.
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 12, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
        cycle(1'b1, 14, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
        cycle(1'b1, 8, 31, 5, 6, 7, 'hFFFF, 0, 1'b0, 1'b0);
        check("illegal_err", err, 1'b1);
        check("illegal_code", err_instr, 4'd12);
        check("illegal_count", count, 3'd1);
        check("jr_word", out_word, 32'h03E0_0008);
        idle(1'b1);
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        check("flush_err", err, 1'b0);
        check("flush_addr", out_addr, 32'h0000_3000);

        // Asynchronous reset mid-stream.
        cycle(1'b1, 3, 29, 4, 0, 0, 'hFFFC, 0, 1'b0, 1'b0);
        cycle(1'b1, 4, 29, 4, 0, 0, 8, 0, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_ready", in_ready, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compare_all();
        cycle(1'b1, 5, 1, 0, 0, 0, 'hFFFF, 0, 1'b0, 1'b0);
        check("beq_word", out_word, 32'h1020_FFFF);
        check("beq_addr", out_addr, 32'h0000_3000);
        idle(1'b1);

        // Randomized traffic including illegal codes and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) < 70, ($urandom_range(9) == 0) ? $urandom_range(15, 10)
                  : $urandom_range(9), $urandom_range(31), $urandom_range(31),
                  $urandom_range(31), $urandom_range(31), $urandom_range(16'hFFFF),
                  $urandom_range(26'h3FF_FFFF), $urandom_range(99) < 55,
                  $urandom_range(99) < 3);
        end

        // Address counter wrap at the top of the address space.
        w_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        w_in_valid = 1'b0;
        check("wrap_count", w_count, 3'd3);
        waddr[0] = 32'hFFFF_FFF8; waddr[1] = 32'hFFFF_FFFC; waddr[2] = 32'h0000_0000;
        w_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("wrap_addr", w_out_addr, waddr[i]);
            check("wrap_word", w_out_word, 32'h0C00_0005);
            @(negedge clk);
        end
        check("wrap_final", w_out_addr, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the opcode/funct decode path. Accepts instruction requests (4-bit instruction code plus operand fields) over a valid/ready handshake and assembles 32-bit MIPS machine words. Buffers encoded words in a small FIFO and emits them with sequential word addresses, for the test-program loader that fills instruction memory.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
BASE_ADDR, 32'h0000_3000, byte address of the first emitted word

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO, address counter and error state
in_valid  input  1  request valid
in_ready  output  1  block can accept
in_instr  input  4  instruction code
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field
in_shamt  input  5  shift amount
in_imm  input  16  immediate / branch offset
in_target  input  26  jal target field
out_valid  output  1  encoded word available
out_ready  input  1  consumer accepts
out_word  output  32  encoded machine word
out_addr  output  32  byte address of out_word
count  output  $clog2(DEPTH)+1  FIFO occupancy
err  output  1  sticky: illegal code seen
err_instr  output  4  code of first illegal request

Behaviour:
- Instruction codes:
  - addu=0, subu=1, ori=2, lw=3, sw=4, beq=5, lui=6, jal=7, jr=8, sll=9.
  - 10..15 are illegal.
- Encoding, fields MSB to LSB:
  - addu: 000000 rs rt rd 00000 100001
  - subu: 000000 rs rt rd 00000 100011
  - jr: 000000 rs 0(15) 001000
  - sll: 000000 00000 rt rd shamt 000000
  - ori: 001101 rs rt imm
  - lw: 100011 rs rt imm
  - sw: 101011 rs rt imm
  - beq: 000100 rs rt imm
  - lui: 001111 00000 rt imm
  - jal: 000011 target
  - Inputs not used by a code are ignored (forced to zero in the word).
- Input fire = in_valid & in_ready. Encoding is combinational on the inputs; the word is written into the FIFO at fire.
- in_ready = !full. There is no bypass when full, even if a pop occurs in the same cycle.
- Illegal code at fire:
  - Request is consumed (in_ready behaves normally), nothing is written to the FIFO.
  - err is set; err_instr latches the code only if err was 0.
- out_valid = !empty. out_word = FIFO head. Word is visible the cycle after its accepting edge (latency 1).
- Output fire = out_valid & out_ready: head popped, address counter += 4.
- out_addr = BASE_ADDR + 4*(words popped since reset/flush), modulo 2^32, with silent wrap.
- Output fire with out_valid=0 has no effect.
- Simultaneous push and pop (not full, not empty): count is unchanged and order is preserved.
- Push and pop when count==1: new word becomes head next cycle.
- count changes +1 on push only, -1 on pop only.
- FIFO is strictly in order. Pointers wrap modulo DEPTH.
- flush:
  - count=0, address counter=BASE_ADDR, err=0, err_instr=0 next cycle.
  - A same-cycle input fire is discarded; any output fire is ignored.
  - flush has priority over all other events.
- reset (low, asynchronous, may occur mid-stream):
  - in_ready=0 while asserted, 1 after release.
  - out_valid=0, count=0, out_addr=BASE_ADDR, err=0, err_instr=0, out_word=0.
  - FIFO contents are don't-care.

Test Plan:
- After reset, push addu rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_word=32'h00221821, out_addr=32'h3000; pop -> out_addr=32'h3004.
- Push ori rs=0 rt=8 imm=16'h1234, lui rt=9 imm=16'hABCD, sll rt=8 rd=10 shamt=2, jal target=26'h0000C00, with out_ready=0 -> count=4, in_ready=0.
  - Release out_ready -> words 32'h34081234, 32'h3C09ABCD, 32'h00085080, 32'h0C000C00 emitted in order at 3000, 3004, 3008, 300C.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> one pop, no push, count=3; the held request is accepted the following cycle.
- Push code 12, then code 14, then jr rs=31 -> err=1, err_instr=12, only 32'h03E00008 emitted. flush -> err=0, out_addr=32'h3000.
- Push lw rs=29 rt=4 imm=16'hFFFC and sw rs=29 rt=4 imm=8; assert reset mid-stream -> out_valid=0, count=0 immediately.
  - After release, beq rs=1 rt=0 imm=16'hFFFF -> 32'h1020FFFF at 32'h3000.
- Set address counter near the top (BASE_ADDR=32'hFFFF_FFF8, 3 pops) -> out_addr sequence FFFFFFF8, FFFFFFFC, 00000000.
